// File: rtl/comp_storage_engine_if.sv
// Command and read-data handshake bundle between the sequencer (master) and
// comp_storage_engine (slave).
interface comp_storage_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addA;
    logic [ADDR_W-1:0] addB;
    logic [ADDR_W-1:0] addC;
    logic [DATA_W-1:0] din;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] dout;
    logic              ovf;

    modport master (
        output cmd_valid, op, addA, addB, addC, din, rd_ready,
        input  cmd_ready, rd_valid, dout, ovf
    );

    modport slave (
        input  cmd_valid, op, addA, addB, addC, din, rd_ready,
        output cmd_ready, rd_valid, dout, ovf
    );
endinterface

// File: rtl/comp_storage_engine.sv
// Register-file compute engine: one operand-capture stage (S1) in front of an
// in-place ALU write-back, with result forwarding and a held RD output slot.
module comp_storage_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter bit SAT_EN = 1'b0
) (
    input logic                  CLK,
    input logic                  RESET_N,
    comp_storage_engine_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_ADD = 3'd3,
        OP_SUB = 3'd4, OP_AND = 3'd5, OP_OR = 3'd6, OP_XOR = 3'd7
    } op_e;

    logic        [DATA_W-1:0] mem_q [DEPTH];
    logic        [DATA_W-1:0] mem_d [DEPTH];
    logic                     vld_p1_q, vld_p1_d;
    op_e                      op_p1_q, op_p1_d;
    logic        [ADDR_W-1:0] addc_p1_q, addc_p1_d;
    logic        [DATA_W-1:0] din_p1_q, din_p1_d;
    logic signed [DATA_W-1:0] a_p1_q, a_p1_d;
    logic signed [DATA_W-1:0] b_p1_q, b_p1_d;
    logic                     rd_valid_q, rd_valid_d;
    logic        [DATA_W-1:0] dout_q, dout_d;
    logic                     ovf_q, ovf_d;
    logic                     retire, accept, cmd_ready, writes_p1, res_ovf;
    logic signed [DATA_W-1:0] res_p1;

    // SUB is A + ~B + 1, so the overflow test uses the inverted B sign.
    function automatic logic [DATA_W:0] add_sub_sat(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b,
                                                    input logic sub);
        logic signed [DATA_W-1:0] bx;
        logic signed [DATA_W-1:0] sum;
        logic                     ov;
        bx  = sub ? ~b : b;
        sum = a + bx + DATA_W'(sub);
        ov  = (a[DATA_W-1] == bx[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        if (SAT_EN && ov)
            sum = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return {ov, sum};
    endfunction

    // Stage p1: execute the captured command
    always_comb begin
        writes_p1 = op_p1_q inside {OP_WR, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
        retire    = vld_p1_q && (op_p1_q != OP_RD || !rd_valid_q || bus.rd_ready);
        cmd_ready = !vld_p1_q || retire;
        accept    = bus.cmd_valid && cmd_ready;
        res_ovf   = 1'b0;
        res_p1    = a_p1_q;
        case (op_p1_q)
            OP_WR:   res_p1 = din_p1_q;
            OP_ADD:  {res_ovf, res_p1} = add_sub_sat(a_p1_q, b_p1_q, 1'b0);
            OP_SUB:  {res_ovf, res_p1} = add_sub_sat(a_p1_q, b_p1_q, 1'b1);
            OP_AND:  res_p1 = a_p1_q & b_p1_q;
            OP_OR:   res_p1 = a_p1_q | b_p1_q;
            OP_XOR:  res_p1 = a_p1_q ^ b_p1_q;
            default: res_p1 = a_p1_q;
        endcase
    end

    // Stage p0: accept a new command, forwarding a result retiring on the same edge
    always_comb begin
        vld_p1_d   = vld_p1_q;
        op_p1_d    = op_p1_q;
        addc_p1_d  = addc_p1_q;
        din_p1_d   = din_p1_q;
        a_p1_d     = a_p1_q;
        b_p1_d     = b_p1_q;
        mem_d      = mem_q;
        rd_valid_d = rd_valid_q;
        dout_d     = dout_q;
        ovf_d      = ovf_q;

        if (retire) vld_p1_d = 1'b0;
        if (accept) begin
            vld_p1_d  = 1'b1;
            op_p1_d   = op_e'(bus.op);
            addc_p1_d = bus.addC;
            din_p1_d  = bus.din;
            a_p1_d    = (retire && writes_p1 && addc_p1_q == bus.addA) ? res_p1 : mem_q[bus.addA];
            b_p1_d    = (retire && writes_p1 && addc_p1_q == bus.addB) ? res_p1 : mem_q[bus.addB];
        end

        if (bus.rd_ready) rd_valid_d = 1'b0;
        if (retire) begin
            if (writes_p1) mem_d[addc_p1_q] = res_p1;
            if (op_p1_q == OP_ADD || op_p1_q == OP_SUB) ovf_d = res_ovf;
            if (op_p1_q == OP_RD) begin
                rd_valid_d = 1'b1;
                dout_d     = a_p1_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            vld_p1_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            dout_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            vld_p1_q   <= vld_p1_d;
            rd_valid_q <= rd_valid_d;
            dout_q     <= dout_d;
            ovf_q      <= ovf_d;
        end
    end

    // S1 payload is qualified by vld_p1_q, so it needs no reset
    always_ff @(posedge CLK) begin
        op_p1_q   <= op_p1_d;
        addc_p1_q <= addc_p1_d;
        din_p1_q  <= din_p1_d;
        a_p1_q    <= a_p1_d;
        b_p1_q    <= b_p1_d;
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
endmodule
